// File: rtl/intr_ctrl8_if.sv
// intr_ctrl8_if: request, mask and valid/ack/eoi signals between the controller and its users
interface intr_ctrl8_if;
    logic [7:0] irq_in;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic [7:0] mask;
    logic [7:0] pending;
    logic [7:0] in_service;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic       irq_ack;
    logic       eoi;
    modport master (
        output irq_in, mask_we, mask_wdata, irq_ack, eoi,
        input  mask, pending, in_service, irq_valid, irq_id
    );
    modport slave (
        input  irq_in, mask_we, mask_wdata, irq_ack, eoi,
        output mask, pending, in_service, irq_valid, irq_id
    );
endinterface

// File: rtl/intr_ctrl8.sv
// intr_ctrl8: 8-source non-nesting interrupt controller, bit 7 highest priority
module intr_ctrl8 #(
    parameter logic [7:0] EDGE_MODE = 8'hFF,
    parameter logic [7:0] MASK_RST  = 8'hFF
) (
    input logic         clk,
    input logic         rst,
    intr_ctrl8_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
    state_t     state, state_n;
    logic [7:0] irq_prev, cand, clr, pending_n;
    logic [2:0] sel;
    logic       take, ack_now, drop, eoi_now;
    assign cand          = bus.pending & ~bus.mask;
    assign bus.irq_valid = state == REQ;
    // highest set candidate bit wins
    always_comb begin
        sel = 3'd0;
        for (int i = 0; i < 8; i++)
            if (cand[i]) sel = 3'(i);
    end
    // handshake decisions and next state; a same-cycle ack beats withdrawal
    always_comb begin
        take    = state == IDLE && cand != 8'd0;
        ack_now = state == REQ && bus.irq_ack;
        drop    = state == REQ && !bus.irq_ack && (!bus.pending[bus.irq_id] || bus.mask[bus.irq_id]);
        eoi_now = state == SERVICE && bus.eoi;
        state_n = take ? REQ : ack_now ? SERVICE : (drop || eoi_now) ? IDLE : state;
    end
    // pending update: level sources mirror the line, edge sources latch until acked and a new edge beats the clear
    always_comb begin
        clr       = ack_now ? (EDGE_MODE & (8'd1 << bus.irq_id)) : 8'd0;
        pending_n = (~EDGE_MODE & bus.irq_in) | (EDGE_MODE & ((bus.pending & ~clr) | (bus.irq_in & ~irq_prev)));
    end
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    // datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev       <= 8'd0;
            bus.pending    <= 8'd0;
            bus.mask       <= MASK_RST;
            bus.in_service <= 8'd0;
            bus.irq_id     <= 3'd0;
        end else begin
            irq_prev    <= bus.irq_in;
            bus.pending <= pending_n;
            if (bus.mask_we) bus.mask <= bus.mask_wdata;
            if (take) bus.irq_id <= sel;
            if (ack_now) bus.in_service <= 8'd1 << bus.irq_id;
            else if (eoi_now) bus.in_service <= 8'd0;
        end
    end
endmodule

// File: tb/tb_intr_ctrl8.sv
// tb_intr_ctrl8: directed plan scenarios plus random traffic against a behavioural model
module tb_intr_ctrl8;
    localparam logic [7:0] EDGE = 8'hEF;
    localparam logic [7:0] MRST = 8'hFF;
    logic clk, rst;
    int   checks, failures;
    intr_ctrl8_if ifc ();
    intr_ctrl8 #(.EDGE_MODE(EDGE), .MASK_RST(MRST)) dut (.clk(clk), .rst(rst), .bus(ifc));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    logic [7:0] m_pend, m_mask, m_prev, m_ins;
    logic       m_valid;
    logic [2:0] m_id;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [2:0] top(input logic [7:0] v);
        for (int i = 7; i >= 0; i--)
            if (v[i]) return 3'(i);
        return 3'd0;
    endfunction
    task automatic model_step(input logic r, input logic [7:0] irq, input logic we,
                              input logic [7:0] wd, input logic ack, input logic e);
        logic [7:0] cand, np;
        logic       clr_i;
        if (r) begin
            m_pend = 0; m_mask = MRST; m_prev = 0; m_ins = 0; m_valid = 0; m_id = 0;
            return;
        end
        cand = m_pend & ~m_mask;
        for (int i = 0; i < 8; i++) begin
            clr_i = m_valid && ack && i == int'(m_id);
            np[i] = EDGE[i] ? ((m_pend[i] && !clr_i) || (irq[i] && !m_prev[i])) : irq[i];
        end
        if (m_valid) begin
            if (ack) begin
                m_ins   = 8'd1 << m_id;
                m_valid = 0;
            end else if (!m_pend[m_id] || m_mask[m_id]) m_valid = 0;
        end else if (m_ins != 0) begin
            if (e) m_ins = 0;
        end else if (cand != 0) begin
            m_id    = top(cand);
            m_valid = 1;
        end
        m_pend = np;
        m_prev = irq;
        if (we) m_mask = wd;
    endtask
    task automatic cyc(input logic [7:0] irq, input logic ack, input logic e,
                       input logic we, input logic [7:0] wd);
        ifc.irq_in = irq; ifc.irq_ack = ack; ifc.eoi = e; ifc.mask_we = we; ifc.mask_wdata = wd;
        @(posedge clk);
        model_step(rst, irq, we, wd, ack, e);
        #1;
        check("mask", ifc.mask, m_mask);
        check("pending", ifc.pending, m_pend);
        check("in_service", ifc.in_service, m_ins);
        check("irq_valid", ifc.irq_valid, m_valid);
        check("irq_id", ifc.irq_id, m_id);
    endtask
    initial begin
        checks = 0; failures = 0;
        rst = 1;
        cyc(0, 0, 0, 0, 0);
        check("rst_mask", ifc.mask, 8'hFF);
        check("rst_valid", ifc.irq_valid, 0);
        rst = 0;
        cyc(0, 0, 0, 1, 8'h00);
        cyc(8'h08, 0, 0, 0, 0);
        check("s1_pend", ifc.pending, 8'h08);
        cyc(0, 0, 0, 0, 0);
        check("s1_valid", ifc.irq_valid, 1);
        check("s1_id", ifc.irq_id, 3);
        cyc(0, 1, 0, 0, 0);
        check("s1_ack_pend", ifc.pending, 8'h00);
        check("s1_ins", ifc.in_service, 8'h08);
        cyc(0, 0, 1, 0, 0);
        check("s1_eoi", ifc.in_service, 8'h00);
        cyc(8'h42, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("s2_id6", ifc.irq_id, 6);
        cyc(8'h80, 0, 0, 0, 0);
        check("s2_nopreempt", ifc.irq_id, 6);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("s2_id7", ifc.irq_id, 7);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("s2_id1", ifc.irq_id, 1);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 8'hFF);
        cyc(8'h04, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("s3_pend", ifc.pending, 8'h04);
        check("s3_masked", ifc.irq_valid, 0);
        cyc(0, 0, 0, 1, 8'hFB);
        check("s3_not_yet", ifc.irq_valid, 0);
        cyc(0, 0, 0, 0, 0);
        check("s3_valid", ifc.irq_valid, 1);
        check("s3_id", ifc.irq_id, 2);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 8'h00);
        cyc(8'h20, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("s4_id5", ifc.irq_id, 5);
        cyc(0, 0, 0, 1, 8'h20);
        cyc(0, 0, 0, 0, 0);
        check("s4_withdraw", ifc.irq_valid, 0);
        check("s4_kept", ifc.pending, 8'h20);
        cyc(0, 0, 0, 1, 8'h00);
        cyc(0, 0, 0, 0, 0);
        check("s4_again", ifc.irq_valid, 1);
        cyc(0, 1, 0, 1, 8'h20);
        check("s4_ackwins", ifc.in_service, 8'h20);
        cyc(0, 0, 1, 1, 8'h00);
        cyc(8'h10, 0, 0, 0, 0);
        cyc(8'h10, 0, 0, 0, 0);
        check("s5_id4", ifc.irq_id, 4);
        cyc(8'h10, 1, 0, 0, 0);
        check("s5_level_pend", ifc.pending, 8'h10);
        cyc(8'h10, 0, 1, 0, 0);
        cyc(8'h10, 0, 0, 0, 0);
        check("s5_repeat", ifc.irq_valid, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("s5_withdrawn", ifc.irq_valid, 0);
        cyc(8'h01, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(8'h01, 1, 0, 0, 0);
        check("s6_setwins", ifc.pending, 8'h01);
        check("s6_ins", ifc.in_service, 8'h01);
        rst = 1;
        cyc(0, 0, 1, 0, 0);
        rst = 0;
        check("s6_rst_ins", ifc.in_service, 0);
        check("s6_rst_pend", ifc.pending, 0);
        check("s6_rst_mask", ifc.mask, 8'hFF);
        check("s6_rst_id", ifc.irq_id, 0);
        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            cyc(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
                $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 15) == 0, 8'($urandom) & 8'($urandom));
        end
        rst = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
